// File: rtl/pmod_dtx2_rx.sv
// rtl/pmod_dtx2_rx.sv - two-digit multiplexed 7-segment receiver
// Settles each digit's pattern per select phase, publishes both as a pair, flags stale select.
module pmod_dtx2_rx #(
  parameter int CLK_IN         = 84_000_000,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit COMMON_ANODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       seg_sel,
  output logic [6:0] digit1_seg,
  output logic [6:0] digit2_seg,
  output logic [3:0] digit1_hex,
  output logic [3:0] digit2_hex,
  output logic [1:0] digit_err,
  output logic       frame_valid,
  output logic       stale
);

  localparam int IW = ($clog2(TIMEOUT_CYCLES + 1) > 24) ? $clog2(TIMEOUT_CYCLES + 1) : 24;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
  localparam logic [15:0]   CNT_LAST = 16'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 || CLK_IN < 1) begin : g_param_err
    $error("pmod_dtx2_rx: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t         r_state, w_state_nxt;
  logic [6:0]     r_seg_s1, r_seg_s2, r_p_prev;
  logic           r_sel_s1, r_sel_s2, r_sel_d;
  logic [15:0]    r_cnt, w_cnt_nxt;
  logic           r_target;
  logic [6:0]     r_sh1, r_sh2;
  logic           r_cap1, r_cap2;
  logic [IW-1:0]  r_idle, w_idle_nxt;
  logic [6:0]     r_d1_seg, r_d2_seg;
  logic [3:0]     r_d1_hex, r_d2_hex;
  logic [1:0]     r_err;
  logic           r_fv, r_stale;
  logic [6:0]     w_p;
  logic           w_sel_edge, w_stable, w_capture, w_publish;
  logic [4:0]     w_dec1, w_dec2;

  // Returns {err, nibble}; unknown patterns decode to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E: decode = 5'h00;
      7'h30: decode = 5'h01;
      7'h6D: decode = 5'h02;
      7'h79: decode = 5'h03;
      7'h33: decode = 5'h04;
      7'h5B: decode = 5'h05;
      7'h5F: decode = 5'h06;
      7'h70: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h7B: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h1F: decode = 5'h0B;
      7'h4E: decode = 5'h0C;
      7'h3D: decode = 5'h0D;
      7'h4F: decode = 5'h0E;
      7'h47: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign w_p        = COMMON_ANODE ? ~r_seg_s2 : r_seg_s2;
  assign w_sel_edge = r_sel_s2 != r_sel_d;
  assign w_stable   = w_p == r_p_prev;
  assign w_publish  = r_cap1 & r_cap2;
  assign w_dec1     = decode(r_sh1);
  assign w_dec2     = decode(r_sh2);
  assign w_idle_nxt = w_sel_edge ? '0 : ((r_idle < IDLE_MAX) ? r_idle + 1'b1 : r_idle);

  // A select edge always restarts settling, abandoning any digit in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (w_sel_edge) begin
      w_state_nxt = SETTLE;
      w_cnt_nxt   = '0;
    end else if (r_state == SETTLE) begin
      if (!w_stable) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_capture   = 1'b1;
        w_state_nxt = HOLD;
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_p_prev <= '0;
      r_sel_s1 <= 1'b0;
      r_sel_s2 <= 1'b0;
      r_sel_d  <= 1'b0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_target <= 1'b0;
      r_sh1    <= '0;
      r_sh2    <= '0;
      r_cap1   <= 1'b0;
      r_cap2   <= 1'b0;
      r_idle   <= '0;
      r_d1_seg <= '0;
      r_d2_seg <= '0;
      r_d1_hex <= '0;
      r_d2_hex <= '0;
      r_err    <= '0;
      r_fv     <= 1'b0;
      r_stale  <= 1'b0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= seg_sel;
      r_sel_s2 <= r_sel_s1;
      r_sel_d  <= r_sel_s2;
      r_p_prev <= w_p;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idle   <= w_idle_nxt;
      r_fv     <= w_publish;
      if (w_sel_edge) begin
        r_target <= r_sel_s2;
      end
      if (w_publish) begin
        r_cap1   <= 1'b0;
        r_cap2   <= 1'b0;
        r_d1_seg <= r_sh1;
        r_d2_seg <= r_sh2;
        r_d1_hex <= w_dec1[3:0];
        r_d2_hex <= w_dec2[3:0];
        r_err    <= {w_dec1[4], w_dec2[4]};
      end
      if (w_capture) begin
        if (r_target) begin
          r_sh1  <= w_p;
          r_cap1 <= 1'b1;
        end else begin
          r_sh2  <= w_p;
          r_cap2 <= 1'b1;
        end
      end
      if (w_publish) begin
        r_stale <= 1'b0;
      end else if (w_idle_nxt == IDLE_MAX) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign digit1_seg  = r_d1_seg;
  assign digit2_seg  = r_d2_seg;
  assign digit1_hex  = r_d1_hex;
  assign digit2_hex  = r_d2_hex;
  assign digit_err   = r_err;
  assign frame_valid = r_fv;
  assign stale       = r_stale;

endmodule

// File: tb/tb_pmod_dtx2_rx.sv
// tb/tb_pmod_dtx2_rx.sv - directed self-checking bench for pmod_dtx2_rx
// Common-anode build, SETTLE_CYCLES=4, TIMEOUT_CYCLES=100; inputs change 1 time unit after a rising edge.
module tb_pmod_dtx2_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_sel;
  logic [6:0] digit1_seg, digit2_seg;
  logic [3:0] digit1_hex, digit2_hex;
  logic [1:0] digit_err;
  logic       frame_valid, stale;

  int n_vec  = 0;
  int n_err  = 0;
  int fv_cnt = 0;
  int fv0    = 0;

  always #5 clk = ~clk;

  pmod_dtx2_rx #(
    .CLK_IN(84_000_000),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(100),
    .COMMON_ANODE(1'b1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .seg_sel(seg_sel),
    .digit1_seg(digit1_seg),
    .digit2_seg(digit2_seg),
    .digit1_hex(digit1_hex),
    .digit2_hex(digit2_hex),
    .digit_err(digit_err),
    .frame_valid(frame_valid),
    .stale(stale)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_valid) fv_cnt++;
  endtask

  task automatic window(input logic sel, input logic [6:0] pat, input int n);
    seg_sel = sel;
    seg_in  = ~pat;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_sel = 1'b0;
    seg_in  = 7'h7F;
    repeat (3) step();
    chk("rst_segs", {digit1_seg, digit2_seg}, 14'h0);
    chk("rst_hex", {digit1_hex, digit2_hex}, 8'h00);
    chk("rst_err", digit_err, 2'b00);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_stale", stale, 1'b0);
    rst_n = 1'b1;

    // Basic frame: 1 then 3
    fv0 = fv_cnt;
    window(1'b1, 7'h30, 20);
    chk("a_no_pub_after_d1", fv_cnt - fv0, 0);
    window(1'b0, 7'h79, 20);
    chk("a_one_pub", fv_cnt - fv0, 1);
    chk("a_hex", {digit1_hex, digit2_hex}, 8'h13);
    chk("a_err", digit_err, 2'b00);
    chk("a_segs", {digit1_seg, digit2_seg}, {7'h30, 7'h79});

    // Unknown pattern on digit 2
    fv0 = fv_cnt;
    window(1'b1, 7'h7E, 20);
    window(1'b0, 7'h01, 20);
    chk("b_pub", fv_cnt - fv0, 1);
    chk("b_hex", {digit1_hex, digit2_hex}, 8'h00);
    chk("b_err", digit_err, 2'b01);
    chk("b_d2_seg", digit2_seg, 7'h01);

    // Unknown pattern on digit 1, then letters A/B
    window(1'b1, 7'h08, 20);
    window(1'b0, 7'h47, 20);
    chk("b2_hex", {digit1_hex, digit2_hex}, 8'h0F);
    chk("b2_err", digit_err, 2'b10);
    window(1'b1, 7'h77, 20);
    window(1'b0, 7'h1F, 20);
    chk("b3_hex", {digit1_hex, digit2_hex}, 8'hAB);
    chk("b3_err", digit_err, 2'b00);

    // Abandoned digit 1, digit 2 captured, then digit 1 under toggling
    window(1'b1, 7'h30, 3);
    fv0 = fv_cnt;
    window(1'b0, 7'h5B, 20);
    chk("c_no_pub_d2_only", fv_cnt - fv0, 0);
    seg_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seg_in = (i % 2 == 1) ? ~7'h30 : ~7'h4F;
      repeat (3) step();
    end
    chk("c_no_pub_toggling", fv_cnt - fv0, 0);
    seg_in = ~7'h7E;
    repeat (7) step();
    chk("c_fv_before", frame_valid, 1'b0);
    step();
    chk("c_fv_at_capture_plus1", frame_valid, 1'b1);
    chk("c_hex", {digit1_hex, digit2_hex}, 8'h05);
    chk("c_d1_seg", digit1_seg, 7'h7E);
    step();
    chk("c_fv_one_clock", frame_valid, 1'b0);

    // Timeout with select held constant
    fv0 = fv_cnt;
    window(1'b0, 7'h3D, 102);
    chk("d_stale_pre", stale, 1'b0);
    step();
    chk("d_stale_set", stale, 1'b1);
    repeat (47) step();
    chk("d_stale_hold", stale, 1'b1);
    chk("d_no_pub", fv_cnt - fv0, 0);
    window(1'b1, 7'h33, 7);
    chk("d_stale_until_pub", stale, 1'b1);
    step();
    chk("d_fv", frame_valid, 1'b1);
    chk("d_stale_clr", stale, 1'b0);
    chk("d_hex", {digit1_hex, digit2_hex}, 8'h4D);
    repeat (12) step();

    // Reset mid-settle after digit 1 captured
    fv0 = fv_cnt;
    window(1'b0, 7'h30, 3);
    window(1'b1, 7'h5F, 20);
    window(1'b0, 7'h6D, 5);
    chk("e_no_pub_pre_rst", fv_cnt - fv0, 0);
    rst_n = 1'b0;
    step();
    step();
    chk("e_rst_segs", {digit1_seg, digit2_seg}, 14'h0);
    chk("e_rst_hex", {digit1_hex, digit2_hex}, 8'h00);
    chk("e_rst_err_fv_stale", {digit_err, frame_valid, stale}, 4'h0);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    window(1'b0, 7'h6D, 20);
    window(1'b1, 7'h7F, 20);
    chk("e_no_pub_d1_only", fv_cnt - fv0, 0);
    window(1'b0, 7'h6D, 20);
    chk("e_pub", fv_cnt - fv0, 1);
    chk("e_hex", {digit1_hex, digit2_hex}, 8'h82);

    // Select edge coincident with the publish clock
    window(1'b1, 7'h1F, 20);
    window(1'b0, 7'h4E, 5);
    fv0 = fv_cnt;
    seg_sel = 1'b1;
    seg_in  = ~7'h5F;
    step();
    step();
    chk("f_fv_early", frame_valid, 1'b0);
    step();
    chk("f_fv_coincident", frame_valid, 1'b1);
    chk("f_hex_coincident", {digit1_hex, digit2_hex}, 8'hBC);
    repeat (17) step();
    chk("f_one_pulse", fv_cnt - fv0, 1);
    window(1'b0, 7'h70, 20);
    chk("f_next_pub", fv_cnt - fv0, 2);
    chk("f_next_hex", {digit1_hex, digit2_hex}, 8'h67);
    chk("f_next_segs", {digit1_seg, digit2_seg}, {7'h5F, 7'h70});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
